// File: rtl/arcade_input_router.sv
// arcade_input_router: merges keyboard, USB and user-port controls into a registered bus with coin shaping.
// Autofire is built only when AUTOFIRE_EN is defined.
module arcade_input_router #(
   parameter int PLAYERS    = 2,
   parameter int BTNS       = 5,
   parameter int COIN_PULSE = 4900000,
   parameter int AF_DIV     = 2450000
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic [10:0]             ps2_key,
   input  logic [PLAYERS*16-1:0]   usb_joy,
   input  logic [PLAYERS*16-1:0]   db_joy,
   input  logic [PLAYERS-1:0]      db_ena,
   input  logic [BTNS-1:0]         af_mask,
   output logic [PLAYERS*BTNS-1:0] ctrl,
   output logic [PLAYERS-1:0]      start,
   output logic [PLAYERS-1:0]      coin,
   output logic                    pause_btn,
   output logic                    service
);
   localparam int CW = $clog2(COIN_PULSE + 1);
   localparam int AW = $clog2(AF_DIV + 1);

   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_t;

   logic        kb_tog;
   logic [6:0]  key_p0;
   logic [3:0]  key_start, key_coin;
   logic        key_service, key_pause;
   logic [12:0] key_ext;
   logic [BTNS-1:0] kb_ctrl;

   always_ff @(posedge clk_sys) begin
      kb_tog <= ps2_key[10];
      if (reset) begin
         key_p0      <= '0;
         key_start   <= '0;
         key_coin    <= '0;
         key_service <= 1'b0;
         key_pause   <= 1'b0;
      end else if (ps2_key[10] != kb_tog) begin
         case (ps2_key[7:0])
            8'h74: key_p0[0]    <= ps2_key[9];
            8'h6B: key_p0[1]    <= ps2_key[9];
            8'h72: key_p0[2]    <= ps2_key[9];
            8'h75: key_p0[3]    <= ps2_key[9];
            8'h14: key_p0[4]    <= ps2_key[9];
            8'h11: key_p0[5]    <= ps2_key[9];
            8'h29: key_p0[6]    <= ps2_key[9];
            8'h16: key_start[0] <= ps2_key[9];
            8'h1E: key_start[1] <= ps2_key[9];
            8'h26: key_start[2] <= ps2_key[9];
            8'h25: key_start[3] <= ps2_key[9];
            8'h2E: key_coin[0]  <= ps2_key[9];
            8'h36: key_coin[1]  <= ps2_key[9];
            8'h3D: key_coin[2]  <= ps2_key[9];
            8'h3E: key_coin[3]  <= ps2_key[9];
            8'h46: key_service  <= ps2_key[9];
            8'h4D: key_pause    <= ps2_key[9];
            default: ;
         endcase
      end
   end

   // fire keys beyond BTNS fall off the top of this slice
   assign key_ext = {6'd0, key_p0};
   assign kb_ctrl = key_ext[BTNS-1:0];

   logic [BTNS-1:0]    raw_ctrl [PLAYERS];
   logic [PLAYERS-1:0] raw_start, raw_coin;
   logic               raw_pause;

   // USB words are dealt out in order to players without a user-port source
   always_comb begin
      int k;
      logic [15:0] src;
      k         = 0;
      src       = '0;
      raw_pause = key_pause;
      for (int p = 0; p < PLAYERS; p++) begin
         src          = db_ena[p] ? db_joy[p*16 +: 16] : usb_joy[k*16 +: 16];
         k            = k + (db_ena[p] ? 0 : 1);
         raw_ctrl[p]  = src[BTNS-1:0] | (p == 0 ? kb_ctrl : '0);
         raw_start[p] = src[BTNS] | key_start[p];
         raw_coin[p]  = src[BTNS+1] | key_coin[p];
         raw_pause    = raw_pause | src[BTNS+2];
      end
   end

   logic [BTNS-1:0] fire [PLAYERS];

`ifdef AUTOFIRE_EN
   logic [PLAYERS-1:0] af_ph, af_ph_n, af_held, af_held_q;
   logic [AW-1:0]      af_cnt [PLAYERS];
   logic [AW-1:0]      af_cnt_n [PLAYERS];

   // a fresh press forces phase 1 so the first shot leaves immediately
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         af_held[p]  = |(raw_ctrl[p] & af_mask);
         af_ph_n[p]  = !af_held[p] ? 1'b0 : !af_held_q[p] ? 1'b1 : (af_cnt[p] == '0) ? ~af_ph[p] : af_ph[p];
         af_cnt_n[p] = !af_held[p] ? '0 : (!af_held_q[p] || af_cnt[p] == '0) ? AW'(AF_DIV - 1) : af_cnt[p] - 1'b1;
         fire[p]     = raw_ctrl[p] & (~af_mask | {BTNS{af_ph_n[p]}});
      end
   end

   always_ff @(posedge clk_sys) begin
      af_ph     <= reset ? '0 : af_ph_n;
      af_held_q <= reset ? '0 : af_held;
      for (int p = 0; p < PLAYERS; p++) af_cnt[p] <= reset ? '0 : af_cnt_n[p];
   end
`else
   logic unused_af;
   assign unused_af = ^af_mask;

   always_comb begin
      for (int p = 0; p < PLAYERS; p++) fire[p] = raw_ctrl[p];
   end
`endif

   coin_st_t           st [PLAYERS];
   coin_st_t           st_n [PLAYERS];
   logic [CW-1:0]      cnt [PLAYERS];
   logic [CW-1:0]      cnt_n [PLAYERS];
   logic [PLAYERS-1:0] coin_prev;

   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         st_n[p]  = st[p];
         cnt_n[p] = cnt[p];
         case (st[p])
            IDLE: begin
               st_n[p]  = (raw_coin[p] && !coin_prev[p]) ? PULSE : IDLE;
               cnt_n[p] = (raw_coin[p] && !coin_prev[p]) ? CW'(COIN_PULSE - 1) : '0;
            end
            PULSE: begin
               st_n[p]  = (cnt[p] == '0) ? GAP : PULSE;
               cnt_n[p] = (cnt[p] == '0) ? CW'(COIN_PULSE - 1) : cnt[p] - 1'b1;
            end
            GAP: begin
               st_n[p]  = (cnt[p] == '0) ? IDLE : GAP;
               cnt_n[p] = (cnt[p] == '0) ? '0 : cnt[p] - 1'b1;
            end
            default: begin
               st_n[p]  = IDLE;
               cnt_n[p] = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         coin_prev <= '0;
         ctrl      <= '0;
         start     <= '0;
         coin      <= '0;
         pause_btn <= 1'b0;
         service   <= 1'b0;
         for (int p = 0; p < PLAYERS; p++) begin
            st[p]  <= IDLE;
            cnt[p] <= '0;
         end
      end else begin
         coin_prev <= raw_coin;
         start     <= raw_start;
         pause_btn <= raw_pause;
         service   <= key_service;
         for (int p = 0; p < PLAYERS; p++) begin
            st[p]               <= st_n[p];
            cnt[p]              <= cnt_n[p];
            coin[p]             <= (st[p] == PULSE);
            ctrl[p*BTNS +: BTNS] <= fire[p];
         end
      end
   end

   logic unused_in;
   assign unused_in = ^{ps2_key[8], key_start, key_coin, key_ext, usb_joy, db_joy};
endmodule

// File: tb/tb_arcade_input_router.sv
// tb_arcade_input_router: directed vectors with a cycle-stamped scoreboard checked at each falling edge.
module tb_arcade_input_router;
   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [31:0] usb_joy, db_joy;
   logic [1:0]  db_ena;
   logic [4:0]  af_mask;
   logic [9:0]  ctrl;
   logic [1:0]  start, coin;
   logic        pause_btn, service;

   arcade_input_router #(.PLAYERS(2), .BTNS(5), .COIN_PULSE(10), .AF_DIV(4)) dut (
      .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .usb_joy(usb_joy), .db_joy(db_joy),
      .db_ena(db_ena), .af_mask(af_mask), .ctrl(ctrl), .start(start), .coin(coin),
      .pause_btn(pause_btn), .service(service)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int          at;
      string       name;
      logic [15:0] mask;
      logic [15:0] val;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          edge_n = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          s;
   logic        tog = 1'b1;
   logic [15:0] obs;

   assign obs = {pause_btn, service, coin, start, ctrl};

   always @(posedge clk_sys) edge_n <= edge_n + 1;

   always @(negedge clk_sys) begin
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
         e = sb.pop_front();
         vectors++;
         if (e.at != edge_n || (obs & e.mask) != e.val) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %h want %h (mask %h)", e.name, e.at, obs & e.mask, e.val, e.mask);
         end
      end
   end

   task automatic expect_v(input int at, input string name, input logic [15:0] mask, input logic [15:0] val);
      exp_t x;
      int   i;
      x.at   = at;
      x.name = name;
      x.mask = mask;
      x.val  = val;
      i = sb.size();
      while (i > 0 && sb[i-1].at > at) i--;
      sb.insert(i, x);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic kb(input logic [7:0] code, input logic pressed);
      tog     = ~tog;
      ps2_key = {tog, pressed, 1'b0, code};
   endtask

   logic [7:0]  kc [5] = '{8'h16, 8'h46, 8'h4D, 8'h14, 8'h74};
   logic [15:0] kv [5] = '{16'h0400, 16'h4000, 16'h8000, 16'h0010, 16'h0001};

   logic [1:0]  rt_ena [7] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
   logic [31:0] rt_usb [7] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h2, 32'h0080_0020, 32'h80};
   logic [31:0] rt_db  [7] = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h0008_0000, 32'h0, 32'h0};
   logic [15:0] rt_exp [7] = '{16'h0024, 16'h0001, 16'h0004, 16'h0001, 16'h0102, 16'h8400, 16'h8000};

   initial begin
      reset   = 1'b1;
      ps2_key = '1;
      usb_joy = '1;
      db_joy  = '1;
      db_ena  = '1;
      af_mask = '1;
      for (int i = 1; i <= 3; i++) expect_v(i, "reset_outputs", 16'hFFFF, 16'h0000);
      step(3);
      usb_joy = '0;
      db_joy  = '0;
      db_ena  = '0;
      af_mask = '0;
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
      step(1);
      reset = 1'b0;
      s = edge_n;
      for (int i = 0; i <= 4; i++) expect_v(s + i, "no_event_after_reset", 16'hFFFF, 16'h0000);
      step(5);

      kb(8'h75, 1'b1);
      s = edge_n;
      expect_v(s + 1, "kb_up_press_lat1", 16'h0008, 16'h0000);
      expect_v(s + 2, "kb_up_press", 16'h0008, 16'h0008);
      step(3);
      kb(8'h75, 1'b0);
      s = edge_n;
      expect_v(s + 1, "kb_up_release_lat1", 16'h0008, 16'h0008);
      expect_v(s + 2, "kb_up_release", 16'h0008, 16'h0000);
      step(3);
      kb(8'h25, 1'b1);
      s = edge_n;
      for (int i = 1; i <= 3; i++) expect_v(s + i, "kb_start_p3_ignored", 16'hFFFF, 16'h0000);
      step(3);
      kb(8'h25, 1'b0);
      step(3);
      for (int i = 0; i < 5; i++) begin
         kb(kc[i], 1'b1);
         s = edge_n;
         expect_v(s + 2, "kb_key_press", 16'hFFFF, kv[i]);
         step(3);
         kb(kc[i], 1'b0);
         s = edge_n;
         expect_v(s + 2, "kb_key_release", 16'hFFFF, 16'h0000);
         step(3);
      end

      for (int i = 0; i < 7; i++) begin
         db_ena  = rt_ena[i];
         usb_joy = rt_usb[i];
         db_joy  = rt_db[i];
         s = edge_n;
         expect_v(s + 1, "route", 16'hFFFF, rt_exp[i]);
         step(2);
         usb_joy = '0;
         db_joy  = '0;
         s = edge_n;
         expect_v(s + 1, "route_clear", 16'hFFFF, 16'h0000);
         step(2);
      end
      db_ena = '0;

      usb_joy = 32'h40;
      s = edge_n;
      for (int i = 0; i <= 34; i++)
         expect_v(s + 1 + i, "coin_shape", 16'h3000,
                  ((i >= 1 && i <= 10) || (i >= 23 && i <= 32)) ? 16'h1000 : 16'h0000);
      step(3);
      usb_joy = '0;
      step(9);
      usb_joy = 32'h40;
      step(3);
      usb_joy = '0;
      step(7);
      usb_joy = 32'h40;
      step(3);
      usb_joy = '0;
      step(20);

      usb_joy = 32'h40;
      s = edge_n;
      for (int i = 0; i <= 19; i++)
         expect_v(s + 1 + i, "coin_reset_mid_pulse", 16'h3000,
                  ((i >= 1 && i <= 4) || (i >= 9 && i <= 18)) ? 16'h1000 : 16'h0000);
      step(1);
      usb_joy = '0;
      step(4);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(2);
      usb_joy = 32'h40;
      step(1);
      usb_joy = '0;
      step(20);

      af_mask = 5'b10000;
      usb_joy = 32'h10;
      s = edge_n;
      for (int i = 0; i <= 19; i++) begin
`ifdef AUTOFIRE_EN
         expect_v(s + 1 + i, "autofire_hold", 16'h0010, ((i / 4) % 2 == 0) ? 16'h0010 : 16'h0000);
`else
         expect_v(s + 1 + i, "autofire_hold", 16'h0010, 16'h0010);
`endif
      end
      expect_v(s + 21, "autofire_release", 16'h0010, 16'h0000);
      expect_v(s + 22, "autofire_release", 16'h0010, 16'h0000);
      expect_v(s + 24, "autofire_repress", 16'h0010, 16'h0010);
      expect_v(s + 25, "autofire_repress", 16'h0010, 16'h0010);
      step(20);
      usb_joy = '0;
      step(3);
      usb_joy = 32'h10;
      step(3);
      usb_joy = '0;
      step(2);

      for (int g = 0; g < 100 && sb.size() > 0; g++) step(1);
      foreach (sb[i]) $display("FAIL %s @edge %0d: never checked, want %h", sb[i].name, sb[i].at, sb[i].val);
      miscompares += sb.size();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/arcade_input_router.md
# arcade_input_router

Parametrised input front end for arcade cores. It merges up to four players' controls from three sources into one registered, active-high control bus for the game core:
- the PS/2 keyboard event word;
- USB joystick words;
- already-decoded DB9/DB15 user-port words.

It also adds coin-pulse shaping and optional autofire. It sits between `hps_io`/joystick decoders and the core's active-low inputs; the top level does the inversion.

## Interface
Parameters:
- `PLAYERS`, 2 — player count, 1..4.
- `BTNS`, 5 — control bits per player, 5..13. Bits 0..3 are R,L,D,U; bits 4.. are fire buttons.
- `COIN_PULSE`, 4900000 — coin output high time, and post-pulse lockout, in clocks (100 ms at 49 MHz).
- `AF_DIV`, 2450000 — autofire half-period in clocks.

Ports:
- `clk_sys` in 1 — system clock.
- `reset` in 1 — synchronous, active-high.
- `ps2_key` in 11 — [10] toggle, [9] pressed, [7:0] scan code; [8] is ignored.
- `usb_joy` in PLAYERS*16 — USB word per player.
  - [BTNS-1:0] controls, [BTNS] start, [BTNS+1] coin, [BTNS+2] pause.
- `db_joy` in PLAYERS*16 — user-port word per player, same layout.
- `db_ena` in PLAYERS — player p takes `db_joy[p]` instead of a USB word.
- `af_mask` in BTNS — buttons subject to autofire. Ignored without `AUTOFIRE_EN`.
- `ctrl` out PLAYERS*BTNS — merged controls.
- `start` out PLAYERS — start buttons.
- `coin` out PLAYERS — shaped coin pulses.
- `pause_btn` out 1 — OR of all pause sources.
- `service` out 1 — service key.

## Operation
- **Source routing** (per player p):
  - If `db_ena[p]`, the source is `db_joy[p]`.
  - Otherwise the source is the k-th USB word, where k = number of players below p that do not have `db_ena` set. USB words are handed out in order to non-DB players.
  - Example: `db_ena`=01, PLAYERS=2 → player 1 gets `usb_joy[0]`.
- **Keyboard:**
  - An event is any change of `ps2_key[10]` against the previously registered copy. On an event, the key bit addressed by the scan code loads `ps2_key[9]`.
  - Player 0 key map:
    - directions: 0x74 R, 0x6B L, 0x72 D, 0x75 U;
    - fires: 0x14 → bit 4, 0x11 → bit 5, 0x29 → bit 6, each only if present in BTNS.
  - Start keys: 0x16/0x1E/0x26/0x25 → start p0..p3.
  - Coin keys: 0x2E/0x36/0x3D/0x3E → coin p0..p3.
  - Other keys: 0x46 → service, 0x4D → pause.
  - Keys for players ≥ PLAYERS, and unmapped codes, are ignored.
- **Merging:** each output = keyboard bit OR routed source bit; `pause_btn` = key OR every routed word's pause bit.
- **Coin shaper:** one FSM per player, input = merged raw coin.
  - IDLE: `coin`=0. A rising edge of raw coin → PULSE, counter loaded to COIN_PULSE-1.
  - PULSE: `coin`=1, counter decrements; at 0 → GAP, counter reloaded to COIN_PULSE-1. Raw activity is ignored.
  - GAP: `coin`=0, counter decrements; at 0 → IDLE. Raw activity is ignored.
  - Retriggering requires a new rising edge. A raw coin held through GAP does not retrigger.
- **Counter width:** $clog2(COIN_PULSE+1) and $clog2(AF_DIV+1) bits; no wrap-around is permitted.

## Timing
- All outputs are registered.
- Joystick input → output: 1 cycle.
- Keyboard event → output: 2 cycles (key register, then output register).
- Coin: `coin` rises 2 cycles after the raw rising edge, stays high exactly COIN_PULSE cycles, then stays low at least COIN_PULSE cycles.
- Reset:
  - all outputs, key state, FSMs (→IDLE), counters and the autofire phase clear to 0;
  - the stored toggle loads the current `ps2_key[10]`, so no spurious event follows reset.
- Reset mid-PULSE drops `coin` on the next cycle.
- A keyboard event on the same cycle as reset deassertion is processed normally.

## Configuration
- `AUTOFIRE_EN` defined:
  - each player has a phase flag and an AF_DIV counter;
  - while any `af_mask` button of that player is held, the phase toggles every AF_DIV cycles;
  - masked outputs = held AND phase;
  - on the first press (none held → some held) the phase is forced to 1 and the counter is restarted, so the first shot is immediate;
  - when all masked buttons are released, the phase returns to 0.
- `AUTOFIRE_EN` undefined: `af_mask` is unused, no autofire logic is built, and all buttons pass through steadily.

## Test plan
- **Reset:** assert `reset` 3 cycles with all inputs set to 1 → every output 0 during reset; no keyboard event after release.
- **Keyboard:** toggle `ps2_key[10]` with code 0x75 pressed → `ctrl[3]`=1 two cycles later; toggle with pressed=0 → `ctrl[3]`=0 two cycles later; code 0x25 with PLAYERS=2 → no output change.
- **Routing:** PLAYERS=2, `db_ena`=01, `usb_joy[0]` bit0=1, `db_joy[0]` bit2=1 → `ctrl[0*BTNS+2]`=1 and `ctrl[1*BTNS+0]`=1 after 1 cycle.
- **Coin:** COIN_PULSE=10, raw coin high 3 cycles, second edge 12 cycles later → `coin[0]` high exactly 10 cycles; second edge (inside GAP) produces nothing; an edge at cycle 22+ pulses again.
- **Autofire** (`AUTOFIRE_EN`, AF_DIV=4, `af_mask` bit4): hold fire 20 cycles → `ctrl[4]` pattern 1111 0000 1111… starting 1 cycle after press; without the macro → steady 1.
- **Reset mid-PULSE:** `reset` at pulse cycle 5 → `coin`=0 next cycle; a new edge after release gives a full 10-cycle pulse.
